// File: rtl/seq_stage_ctrl_if.sv
// seq_stage_ctrl_if: control/status bundle between the SEQ stage sequencer
// and the datapath (fetch flags, memory flags, next PC, stage enables).
interface seq_stage_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic             step_req;
    logic             instr_valid;
    logic             imem_error;
    logic             hlt;
    logic             dmem_error;
    logic [63:0]      updated_pc;
    logic [63:0]      pc;
    logic             en_fetch;
    logic             en_decode;
    logic             en_execute;
    logic             en_memory;
    logic             en_wb;
    logic             en_pcupd;
    logic [2:0]       stat;
    logic             busy;
    logic [CNT_W-1:0] retired;

    // Sequencer side
    modport master (
        input  start, step_req, instr_valid, imem_error, hlt, dmem_error, updated_pc,
        output pc, en_fetch, en_decode, en_execute, en_memory, en_wb, en_pcupd,
               stat, busy, retired
    );

    // Datapath / environment side
    modport slave (
        output start, step_req, instr_valid, imem_error, hlt, dmem_error, updated_pc,
        input  pc, en_fetch, en_decode, en_execute, en_memory, en_wb, en_pcupd,
               stat, busy, retired
    );
endinterface

// File: rtl/seq_stage_ctrl.sv
// seq_stage_ctrl: multi-cycle stage sequencer for the Y86-64 SEQ datapath.
// Owns the architectural PC, processor status and retired-instruction count,
// and enables one stage per clock. Stops permanently on any exception.
// Optional single-step mode is compiled in with SEQ_CTRL_STEP_EN.
module seq_stage_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned CNT_W    = 32
) (
    input logic              clk,
    input logic              rst_n,
    seq_stage_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXECUTE, MEMORY, WB, PCUPD, WAIT_STEP, STOP
    } state_t;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    state_t           state_q, state_d;
    stat_t            stat_q, stat_d;
    logic [63:0]      pc_q, pc_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic en_fetch, en_decode, en_execute, en_memory, en_wb, en_pcupd;
    logic busy;

`ifndef SEQ_CTRL_STEP_EN
    logic unused_step_req;
    assign unused_step_req = bus.step_req;
`endif

    // State register: synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            stat_q    <= STAT_AOK;
            pc_q      <= RESET_PC;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            stat_q    <= stat_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    // Next-state: stage sequencing, exception capture, PC/retire update
    always_comb begin
        state_d   = state_q;
        stat_d    = stat_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = FETCH;
            end
            FETCH: begin
                if (bus.imem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = STOP;
                end else if (!bus.instr_valid) begin
                    stat_d  = STAT_INS;
                    state_d = STOP;
                end else if (bus.hlt) begin
                    stat_d  = STAT_HLT;
                    state_d = STOP;
                end else begin
                    state_d = DECODE;
                end
            end
            DECODE:  state_d = EXECUTE;
            EXECUTE: state_d = MEMORY;
            MEMORY: begin
                if (bus.dmem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = STOP;
                end else begin
                    state_d = WB;
                end
            end
            WB: state_d = PCUPD;
            PCUPD: begin
                pc_d      = bus.updated_pc;
                retired_d = retired_q + CNT_W'(1);
`ifdef SEQ_CTRL_STEP_EN
                state_d   = WAIT_STEP;
`else
                state_d   = FETCH;
`endif
            end
            WAIT_STEP: begin
`ifdef SEQ_CTRL_STEP_EN
                if (bus.step_req) state_d = FETCH;
`endif
            end
            STOP: state_d = STOP;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: one-hot stage enables decoded from the state register
    always_comb begin
        en_fetch   = 1'b0;
        en_decode  = 1'b0;
        en_execute = 1'b0;
        en_memory  = 1'b0;
        en_wb      = 1'b0;
        en_pcupd   = 1'b0;
        busy       = 1'b1;
        case (state_q)
            FETCH:      en_fetch   = 1'b1;
            DECODE:     en_decode  = 1'b1;
            EXECUTE:    en_execute = 1'b1;
            MEMORY:     en_memory  = 1'b1;
            WB:         en_wb      = 1'b1;
            PCUPD:      en_pcupd   = 1'b1;
            IDLE, STOP: busy       = 1'b0;
            default:    busy       = 1'b1;
        endcase
    end

    assign bus.pc         = pc_q;
    assign bus.stat       = stat_q;
    assign bus.retired    = retired_q;
    assign bus.busy       = busy;
    assign bus.en_fetch   = en_fetch;
    assign bus.en_decode  = en_decode;
    assign bus.en_execute = en_execute;
    assign bus.en_memory  = en_memory;
    assign bus.en_wb      = en_wb;
    assign bus.en_pcupd   = en_pcupd;

endmodule
